// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 Wishbone front end and its neighbours.
// Register offsets are word indices (byte address bits [7:2]).
package sha1_pkg;

    localparam logic [5:0] OFF_CTRL    = 6'h00;
    localparam logic [5:0] OFF_STATUS  = 6'h01;
    localparam logic [5:0] OFF_DIGEST0 = 6'h02;
    localparam logic [5:0] OFF_MSG0    = 6'h10;

    localparam int CTRL_START  = 0;
    localparam int CTRL_INIT   = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } sha1_state_e;

    localparam logic [31:0] SHA1_IV_H0 = 32'h6745_2301;
    localparam logic [31:0] SHA1_IV_H1 = 32'hEFCD_AB89;
    localparam logic [31:0] SHA1_IV_H2 = 32'h98BA_DCFE;
    localparam logic [31:0] SHA1_IV_H3 = 32'h1032_5476;
    localparam logic [31:0] SHA1_IV_H4 = 32'hC3D2_E1F0;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old,
        input logic [31:0] dat,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha1_wb_regs.sv
// Wishbone register front end for the SHA-1 core: message buffer, control,
// status, digest capture and interrupt.
module sha1_wb_regs
    import sha1_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_ni,
    input  logic         wbs_stb_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    output logic [511:0] blk_o,
    output logic         blk_init_o,
    output logic         blk_valid_o,
    input  logic         blk_ready_i,
    input  logic [159:0] digest_i,
    input  logic         digest_valid_i,
    output logic         irq_o
);

    sha1_state_e  state_q;
    logic [31:0]  msg_q [16];
    logic [159:0] digest_q;
    logic         init_q;
    logic         irq_en_q;
    logic         done_q;
    logic         done_d;
    logic         err_q;
    logic         err_d;
    logic         blk_valid_q;
    logic         blk_init_q;
    logic         irq_q;
    logic         ack_q;
    logic         served_q;
    logic [31:0]  dat_q;
    logic [31:0]  rdata;

    logic         hit;
    logic         acc;
    logic         wr;
    logic [5:0]   off;
    logic         busy;
    logic         ctrl_wr;
    logic         stat_wr;
    logic         start;
    logic         msg_hit;
    logic         msg_wr;
    logic         dig;

    assign hit = wbs_stb_i & wbs_cyc_i
               & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    // One transfer per strobe assertion: a held strobe is served once.
    assign acc     = hit & ~served_q;
    assign wr      = acc & wbs_we_i;
    assign off     = wbs_adr_i[7:2];
    assign busy    = (state_q != IDLE);
    assign ctrl_wr = wr & (off == OFF_CTRL) & wbs_sel_i[0];
    assign stat_wr = wr & (off == OFF_STATUS) & wbs_sel_i[0];
    assign start   = ctrl_wr & wbs_dat_i[CTRL_START];
    assign msg_hit = (off[5:4] == OFF_MSG0[5:4]);
    assign msg_wr  = wr & msg_hit;
    assign dig     = digest_valid_i & (state_q == WAIT);

    always_comb begin
        rdata = '0;
        if (msg_hit) begin
            rdata = msg_q[off[3:0]];
        end else begin
            unique case (off)
                OFF_CTRL:    rdata = {29'b0, irq_en_q, init_q, 1'b0};
                OFF_STATUS:  rdata = {29'b0, err_q, done_q, busy};
                OFF_DIGEST0: rdata = digest_q[159:128];
                OFF_DIGEST0 + 6'd1: rdata = digest_q[127:96];
                OFF_DIGEST0 + 6'd2: rdata = digest_q[95:64];
                OFF_DIGEST0 + 6'd3: rdata = digest_q[63:32];
                OFF_DIGEST0 + 6'd4: rdata = digest_q[31:0];
                default:     rdata = '0;
            endcase
        end
    end

    // Later assignments take priority: a core DONE beats a W1C clear.
    always_comb begin
        done_d = done_q;
        if (stat_wr && wbs_dat_i[ST_DONE]) done_d = 1'b0;
        if (start && !busy)                done_d = 1'b0;
        if (dig)                           done_d = 1'b1;
        err_d = err_q;
        if (stat_wr && wbs_dat_i[ST_ERR])  err_d = 1'b0;
        if ((start || msg_wr) && busy)     err_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            served_q <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            init_q   <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            served_q <= hit;
            ack_q    <= acc;
            dat_q    <= (acc && !wbs_we_i) ? rdata : '0;
            done_q   <= done_d;
            err_q    <= err_d;
            irq_q    <= done_q & irq_en_q;
            if (ctrl_wr) begin
                init_q   <= wbs_dat_i[CTRL_INIT];
                irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < 16; i++) msg_q[i] <= '0;
        end else if (msg_wr && !busy) begin
            msg_q[off[3:0]] <= byte_merge(msg_q[off[3:0]], wbs_dat_i,
                                          wbs_sel_i);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            blk_valid_q <= 1'b0;
            blk_init_q  <= 1'b0;
            digest_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    state_q     <= SEND;
                    blk_valid_q <= 1'b1;
                    blk_init_q  <= wbs_dat_i[CTRL_INIT];
                end
                SEND: if (blk_ready_i) begin
                    state_q     <= WAIT;
                    blk_valid_q <= 1'b0;
                end
                WAIT: if (digest_valid_i) begin
                    state_q  <= IDLE;
                    digest_q <= digest_i;
                end
                default: begin
                    state_q     <= IDLE;
                    blk_valid_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_blk
        assign blk_o[511-32*g -: 32] = msg_q[g];
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign blk_init_o  = blk_init_q;
    assign blk_valid_o = blk_valid_q;
    assign irq_o       = irq_q;

endmodule

// File: doc/sha1_wb_regs.md
Name: sha1_wb_regs

Overview:
- Wishbone slave front end for the SHA-1 user project, directly upstream of the SHA-1 compression core inside wrapper_sha1.
- Firmware writes sixteen 32-bit message words and a control word over Wishbone. The block then presents one 512-bit block to the core with a valid/ready handshake.
- It captures the 160-bit digest the core returns and exposes it, plus status and an interrupt, for readback.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base address of the register window.
- ADDR_MASK, 32'hFFFF_FF00, bits that must match BASE_ADDR for the block to respond (256-byte window).

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge
- wb_rst_ni  in  1  asynchronous active-low reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte lanes; writes honour per-byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- blk_o  out  512  message block; W0 in bits [511:480]
- blk_init_o  out  1  block starts a new hash (core reloads H0..H4 IV)
- blk_valid_o  out  1  block offered to core
- blk_ready_i  in  1  core accepts block
- digest_i  in  160  digest from core; H0 in bits [159:128]
- digest_valid_i  in  1  one-cycle pulse: digest_i valid
- irq_o  out  1  interrupt to irq[0]

Behaviour:
- Reset (async assert, sync release): all outputs 0; message words, digest, CTRL and STATUS cleared; FSM in IDLE.
- Address decode:
  - Hit when (wbs_adr_i & ADDR_MASK) == BASE_ADDR and stb & cyc.
  - Offset = wbs_adr_i[7:2].
  - No hit: no ack, wbs_dat_o = 0.
- Ack timing:
  - wbs_ack_o registered: asserts the cycle after a hit, for exactly one cycle.
  - wbs_ack_o is never asserted two cycles in a row, so a held strobe gets one ack per transfer.
  - Reads sample and register data in the same edge as ack.
- Register map, byte offsets:
  - 0x00 CTRL
    - W: bit0 START (self-clearing pulse, reads 0), bit1 INIT (stored), bit2 IRQ_EN (stored).
    - R: {29'b0, IRQ_EN, INIT, 1'b0}.
  - 0x04 STATUS
    - R: {29'b0, ERR, DONE, BUSY}.
    - W: write-1-to-clear for DONE (bit1) and ERR (bit2); BUSY is read-only.
  - 0x08–0x18 DIGEST H0..H4, read-only. Writes are acked and ignored.
  - 0x40–0x7C MSG W0..W15, read/write.
  - Any other in-window offset: acked, reads 0, writes ignored.
- FSM states: IDLE, SEND, WAIT.
  - IDLE: a START write with BUSY=0 latches INIT into blk_init_o, clears DONE, and goes to SEND next cycle.
  - SEND: blk_valid_o = 1, blk_o = message buffer. On blk_valid_o & blk_ready_i, go to WAIT. blk_valid_o drops the following cycle.
  - WAIT: on digest_valid_i, latch digest_i into DIGEST, set DONE, go to IDLE.
  - BUSY = (state != IDLE).
- Boundary conditions:
  - START while BUSY: ignored, ERR set.
  - MSG write while BUSY: data dropped (buffer stable while core may sample it), ERR set, still acked.
  - digest_valid_i outside WAIT: ignored.
  - START and DONE W1C in the same cycle (separate writes cannot coincide; any CTRL write clears DONE on START): START wins and DONE ends at 0.
  - DONE set by the core in the same cycle as a DONE W1C: set wins.
  - INIT stays as written: firmware clears it for continuation blocks. The message buffer persists across blocks.
- irq_o: registered DONE & IRQ_EN. Clearing either drops it the next cycle.
- Reset mid-operation: asynchronous return to IDLE, all state cleared, and blk_valid_o drops immediately.

Decomposition:
- Shared package sha1_pkg:
  - register offset localparams: CTRL, STATUS, DIGEST0, MSG0
  - FSM state enum {IDLE, SEND, WAIT}
  - STATUS/CTRL bit index constants
  - SHA-1 IV constants, for the core and the bench
- No sub-module required; the message buffer is a flat 16x32 register array inside the block.

Test Plan:
- Reset: hold wb_rst_ni=0 mid-SEND → blk_valid_o drops asynchronously, STATUS reads 0x0, irq_o=0.
- "abc" block:
  - Stimulus: write MSG W0=0x61626380, W1..W14=0, W15=0x00000018; write CTRL=0x7.
  - Bench core model accepts after 3 cycles and returns digest 20 cycles later.
  - Required: blk_o[511:480]=0x61626380, blk_init_o=1, DIGEST reads A9993E36 4706816A BA3E2571 7850C26C 9CD0D89D, STATUS=0x2, irq_o=1.
- Held-off handshake: blk_ready_i low for 10 cycles → blk_valid_o held 1 with stable blk_o, BUSY=1 throughout.
- Busy errors: during WAIT, write MSG W3=0xDEADBEEF and write CTRL=0x1 → W3 unchanged, no second blk_valid_o, STATUS=0x5. Writing STATUS=0x4 gives STATUS=0x1.
- Byte lanes and decode:
  - Write W0=0x11223344 with sel=4'b0101 over prior 0 → reads 0x00220044.
  - Access at BASE_ADDR+0x100 → no ack.
  - Read at offset 0x30 → ack, data 0.
- W1C/IRQ: after DONE with IRQ_EN=1, write STATUS=0x2 → DONE=0, irq_o falls the next cycle. A held strobe for 4 cycles yields exactly one ack.
